// File: rtl/seq_alu_exec.sv
// rtl/seq_alu_exec.sv - execution-stage ALU: single-cycle logic/add/lui, iterative shifts
module seq_alu_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             alu_operation,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   zero,
  output logic                   illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                 state, state_n;
  logic [DATA_WIDTH-1:0]  acc, acc_n;
  logic [SHAMT_WIDTH-1:0] cnt, cnt_n;
  logic                   dir_right, dir_right_n;
  logic [DATA_WIDTH-1:0]  result_n;
  logic                   zero_n, illegal_n, done_n;
  logic [DATA_WIDTH-1:0]  acc_step;

  // busy is simply "a shift is iterating"; start is ignored while it is high
  assign busy = (state == SHIFT);

  // register all state; reset overrides any request or in-flight shift
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      dir_right <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
      illegal   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      dir_right <= dir_right_n;
      result    <= result_n;
      zero      <= zero_n;
      illegal   <= illegal_n;
      done      <= done_n;
    end
  end

  // next-state and datapath: accept in IDLE, one bit of shift per cycle in SHIFT
  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    dir_right_n = dir_right;
    result_n    = result;
    zero_n      = zero;
    illegal_n   = illegal;
    done_n      = 1'b0;
    acc_step    = dir_right ? (acc >> 1) : (acc << 1);

    case (state)
      IDLE: begin
        if (start) begin
          done_n    = 1'b1;
          illegal_n = 1'b0;
          case (alu_operation)
            OP_AND: result_n = a & b;
            OP_OR:  result_n = a | b;
            OP_NOR: result_n = ~(a | b);
            OP_ADD: result_n = a + b;
            OP_LUI: result_n = {b[15:0], {(DATA_WIDTH-16){1'b0}}};
            OP_SLL, OP_SRL: begin
              if (shamt == '0) begin
                result_n = b;
              end else begin
                // result registers hold their old value until the shift completes
                result_n    = result;
                illegal_n   = illegal;
                done_n      = 1'b0;
                acc_n       = b;
                cnt_n       = shamt;
                dir_right_n = (alu_operation == OP_SRL);
                state_n     = SHIFT;
              end
            end
            default: begin
              result_n  = '0;
              illegal_n = 1'b1;
            end
          endcase
          zero_n = (result_n == '0);
        end
      end
      SHIFT: begin
        acc_n = acc_step;
        cnt_n = cnt - SHAMT_WIDTH'(1);
        if (cnt == SHAMT_WIDTH'(1)) begin
          result_n  = acc_step;
          zero_n    = (acc_step == '0);
          illegal_n = 1'b0;
          done_n    = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_seq_alu_exec.sv
// tb/tb_seq_alu_exec.sv - scoreboard bench for seq_alu_exec
module tb_seq_alu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_operation;
  logic [31:0] a, b;
  logic [4:0]  shamt;
  logic        busy, done, zero, illegal;
  logic [31:0] result;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        i;
    int          c;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   busy_cnt = 0;
  int   compared = 0;
  int   mismatched = 0;

  seq_alu_exec #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .alu_operation(alu_operation),
    .a(a), .b(b), .shamt(shamt), .busy(busy), .done(done),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // cycle index: after posedge k, cyc == k
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("result", result, e.r);
        check("zero", {31'b0, zero}, {31'b0, e.z});
        check("illegal", {31'b0, illegal}, {31'b0, e.i});
        check("done_cycle", cyc, e.c);
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [4:0] sh, input logic [31:0] er, input logic ez, input logic ei);
    exp_t e;
    int extra;
    extra = ((op == 4'b0110 || op == 4'b0111) && sh != 0) ? int'(sh) : 0;
    e.r = er; e.z = ez; e.i = ei; e.c = cyc + 1 + extra;
    q.push_back(e);
    start = 1'b1; alu_operation = op; a = ia; b = ib; shamt = sh;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; alu_operation = 4'b0; a = '0; b = '0; shamt = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_result", result, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_illegal", {31'b0, illegal}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // single-cycle ops
    issue(4'b0011, 32'hFFFF_FFFF, 32'h1, 5'd0, 32'h0, 1'b1, 1'b0);
    issue(4'b0010, 32'h0, 32'h0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    issue(4'b0101, 32'h0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, 1'b0);
    issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF000_F000, 1'b0, 1'b0);
    issue(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hFFF0_FFF0, 1'b0, 1'b0);
    drain();

    // shifts
    busy_cnt = 0;
    issue(4'b0110, 32'h0, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    drain();
    check("sll31_busy_cycles", busy_cnt, 32'd31);
    busy_cnt = 0;
    issue(4'b0111, 32'h0, 32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0);
    drain();
    check("srl4_busy_cycles", busy_cnt, 32'd4);
    issue(4'b0110, 32'h0, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    drain();

    // start while busy is ignored; only the SRL completes
    issue(4'b0111, 32'h0, 32'h1234_5678, 5'd8, 32'h0012_3456, 1'b0, 1'b0);
    start = 1'b1; alu_operation = 4'b0011; a = 32'h1; b = 32'h1; shamt = 5'd0;
    repeat (3) @(posedge clk); #1;
    start = 1'b0;
    drain();

    // illegal codes, then a legal op clears illegal
    issue(4'b1001, 32'h5, 32'h7, 5'd0, 32'h0, 1'b1, 1'b1);
    issue(4'b1111, 32'h5, 32'h7, 5'd0, 32'h0, 1'b1, 1'b1);
    issue(4'b0001, 32'h0, 32'h5, 5'd0, 32'h5, 1'b0, 1'b0);
    drain();

    // reset mid-shift, with a simultaneous start that must be dropped
    start = 1'b1; alu_operation = 4'b0110; a = '0; b = 32'h1; shamt = 5'd20;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("midshift_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1; start = 1'b1; alu_operation = 4'b0011; a = 32'h1; b = 32'h1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    check("abort_result", result, 32'h0);
    check("abort_zero", {31'b0, zero}, 32'h1);
    repeat (25) @(posedge clk); #1;
    issue(4'b0011, 32'h2, 32'h3, 5'd0, 32'h5, 1'b0, 1'b0);
    drain();

    check("queue_empty", q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seq_alu_exec.md
Name: seq_alu_exec

Overview:
- Execution-stage ALU that consumes the 4-bit ALU operation code from the ALU control unit.
- Performs AND/OR/NOR/ADD/LUI in one cycle.
- Performs SLL/SRL iteratively, one bit per cycle, with a start/done handshake.
- Sits between ALU control and the writeback mux; the pipeline stalls on busy.

Parameters:
- DATA_WIDTH, 32, operand/result width
- SHAMT_WIDTH, 5, shift-amount width; must be log2(DATA_WIDTH)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when busy=0
- alu_operation  input  4  code from ALU control, sampled on accept
- a  input  DATA_WIDTH  operand A (rs), sampled on accept
- b  input  DATA_WIDTH  operand B (rt/immediate), sampled on accept
- shamt  input  SHAMT_WIDTH  shift amount, sampled on accept
- busy  output  1  high while a shift iterates
- done  output  1  one-cycle pulse; result/zero/illegal valid
- result  output  DATA_WIDTH  registered result, held until next done
- zero  output  1  registered (result==0), updated with result
- illegal  output  1  registered; high with done for unsupported code

Behaviour:
- Operation codes:
  - 0000 AND: a&b
  - 0001 OR: a|b
  - 0010 NOR: ~(a|b)
  - 0011 ADD: a+b, modulo 2^DATA_WIDTH, carry/overflow discarded
  - 0101 LUI: {b[15:0],16'h0000}
  - 0110 SLL: b<<shamt, logical
  - 0111 SRL: b>>shamt, logical, zero fill
  - all other codes, including 1001: illegal
- Reset (synchronous, has priority over everything):
  - state=IDLE, busy=0, done=0, result=0, zero=1, illegal=0, internal accumulator and counter=0.
  - Asserted mid-shift: the operation aborts, no done is produced, and outputs take reset values on the next edge.
- States: IDLE, SHIFT.
  - IDLE: start=1 accepts the request at edge T; all inputs are captured at that edge.
  - Non-shift op, or shift with shamt=0 (result=b):
    - result, zero and illegal are registered at edge T; done=1 during cycle T+1.
    - State stays IDLE.
  - Illegal code: result=0, zero=1, illegal=1, done=1 during T+1.
  - Shift with shamt>0:
    - At edge T: acc=b, cnt=shamt, state goes to SHIFT.
    - busy=1 during cycles T+1..T+shamt.
  - SHIFT: each edge shifts acc one bit in the selected direction and does cnt=cnt-1.
    - On the edge where cnt==1: result=shifted acc, zero updates, illegal=0, state returns to IDLE.
    - done=1 during cycle T+1+shamt; busy=0 in that cycle.
- Latency: 1 cycle for non-shift ops; 1+shamt cycles for shifts (max 32 at shamt=31).
- done is asserted for exactly one cycle per accepted request.
- Back-to-back:
  - start is accepted in the same cycle done is high (busy=0).
  - Non-shift ops sustain one per cycle; done stays high on consecutive cycles, each pulse belonging to a distinct request.
- Simultaneous events:
  - start while busy=1 is ignored with no queuing; inputs are not sampled.
  - start together with reset: reset wins and the request is dropped.
- Input changes after accept have no effect on an in-flight operation.
- result, zero and illegal hold their last values between done pulses.
- Only done marks new data.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> result=0, zero=1, busy=0, done=0, illegal=0.
- Single-cycle ops:
  - ADD a=0xFFFFFFFF, b=1 -> done at T+1, result=0, zero=1.
  - NOR a=0, b=0 -> result=0xFFFFFFFF, zero=0.
  - LUI b=0x00001234 -> result=0x12340000.
  - Back-to-back AND/OR on consecutive cycles -> done high on both following cycles with the correct results.
- Shifts:
  - SLL b=0x00000001, shamt=31 -> busy high 31 cycles, done at T+32, result=0x80000000.
  - SRL b=0x80000000, shamt=4 -> done at T+5, result=0x08000000.
  - SLL shamt=0 -> done at T+1, result=b.
- Busy ignore: start=1 with ADD during a SRL shamt=8 -> ADD not executed; only one done pulse, at T+9, carrying the SRL result.
- Illegal code: alu_operation=1001, then 1111 -> each gives done at T+1 with illegal=1, result=0, zero=1; a following legal op gives illegal=0.
- Reset mid-shift: SLL shamt=20, reset asserted at cycle T+5 -> no done pulse, busy=0 and result=0 after the edge; a new ADD is accepted normally afterwards.
